// File: rtl/keypad_emu_pkg.sv
// keypad_emu_pkg: shared types and helpers for the keypad emulator.
//   state_e       - contact FSM states
//   cmd_res_e     - outcome of a command presented while ready
//   check_cmd()   - classifies a command against the current state/latched key
package keypad_emu_pkg;

  localparam int SCAN_IDX_W  = 2;
  localparam int SENSE_IDX_W = 3;

  typedef enum logic [1:0] {IDLE, BOUNCE_DN, HELD, BOUNCE_UP} state_e;
  typedef enum logic [1:0] {CMD_ACCEPT, CMD_IGNORE, CMD_REJECT} cmd_res_e;

  // Only meaningful in IDLE/HELD; bounce states never sample commands.
  function automatic cmd_res_e check_cmd(
    input state_e                 st,
    input logic                   press,
    input logic [SCAN_IDX_W-1:0]  scan,
    input logic [SENSE_IDX_W-1:0] sense,
    input logic [SCAN_IDX_W-1:0]  lat_scan,
    input logic [SENSE_IDX_W-1:0] lat_sense,
    input int                     n_scan,
    input int                     n_sense
  );
    cmd_res_e res;
    logic     same;
    same = (scan == lat_scan) && (sense == lat_sense);
    res  = CMD_IGNORE;
    if (int'(scan) >= n_scan || int'(sense) >= n_sense) begin
      res = CMD_REJECT;
    end else begin
      case (st)
        IDLE:    res = press ? CMD_ACCEPT : CMD_REJECT;
        HELD:    res = press ? (same ? CMD_IGNORE : CMD_REJECT)
                             : (same ? CMD_ACCEPT : CMD_REJECT);
        default: res = CMD_IGNORE;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_emulator_bounce_timer.sv
// bounce_timer: times a bounce sequence of BOUNCE_PERIODS periods, each
// BOUNCE_CYCLES clocks long.
//   clk, rst  - clock, synchronous active-high reset
//   start_i   - (re)starts the sequence at period 0, cycle 0
//   parity_o  - LSB of the current period index
//   done_o    - high during the last cycle of the last period
module bounce_timer #(
  parameter int BOUNCE_CYCLES  = 8,
  parameter int BOUNCE_PERIODS = 4,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic parity_o,
  output logic done_o
);

  localparam int PER_W = (BOUNCE_PERIODS > 2) ? $clog2(BOUNCE_PERIODS) : 1;

  logic             active_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PER_W-1:0] per_q;
  logic             last_cyc, last_per;

  assign last_cyc = (cnt_q == CNT_W'(BOUNCE_CYCLES - 1));
  assign last_per = (per_q == PER_W'(BOUNCE_PERIODS - 1));
  assign done_o   = active_q & last_cyc & last_per;
  assign parity_o = per_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      per_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      per_q    <= '0;
    end else if (active_q) begin
      if (last_cyc) begin
        cnt_q <= '0;
        per_q <= per_q + PER_W'(1);
        if (last_per) active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: single-key matrix keypad model (responder side of a scan
// interface) with programmable contact bounce.
//   clk, rst                 - clock, synchronous active-high reset
//   cmd_valid/cmd_ready      - command handshake
//   cmd_press/scan/sense     - press(1)/release(0) of key (scan, sense)
//   scan_in                  - scanner scan lines, active-low
//   sense_out                - sense lines back to scanner, active-low, registered
//   key_down                 - contact settled closed
//   err                      - one-cycle pulse on a rejected command
module keypad_emulator
  import keypad_emu_pkg::*;
#(
  parameter int N_SCAN         = 4,
  parameter int N_SENSE        = 6,
  parameter int BOUNCE_CYCLES  = 8,
  parameter int BOUNCE_PERIODS = 4,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_press,
  input  logic [SCAN_IDX_W-1:0]  cmd_scan,
  input  logic [SENSE_IDX_W-1:0] cmd_sense,
  input  logic [N_SCAN-1:0]      scan_in,
  output logic [N_SENSE-1:0]     sense_out,
  output logic                   key_down,
  output logic                   err
);

  state_e                 state_q;
  logic [SCAN_IDX_W-1:0]  scan_q;
  logic [SENSE_IDX_W-1:0] sense_idx_q;
  logic [N_SENSE-1:0]     sense_q, sense_d;
  logic                   ready_q, key_down_q, err_q;
  logic                   parity, done, contact, start;
  cmd_res_e               res;

  assign res   = check_cmd(state_q, cmd_press, cmd_scan, cmd_sense,
                           scan_q, sense_idx_q, N_SCAN, N_SENSE);
  assign start = cmd_valid & ready_q & (res == CMD_ACCEPT);

  bounce_timer #(
    .BOUNCE_CYCLES (BOUNCE_CYCLES),
    .BOUNCE_PERIODS(BOUNCE_PERIODS),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .parity_o(parity),
    .done_o  (done)
  );

  // Press bounce starts closed, release bounce starts open.
  always_comb begin
    contact = 1'b0;
    case (state_q)
      BOUNCE_DN: contact = ~parity;
      HELD:      contact = 1'b1;
      BOUNCE_UP: contact = parity;
      default:   contact = 1'b0;
    endcase
  end

  // Only the latched scan line can pull the latched sense line low.
  always_comb begin
    sense_d = '1;
    if (contact && !scan_in[scan_q]) sense_d[sense_idx_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sense_q <= '1;
    else     sense_q <= sense_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      key_down_q  <= 1'b0;
      err_q       <= 1'b0;
      scan_q      <= '0;
      sense_idx_q <= '0;
    end else begin
      err_q <= cmd_valid & ready_q & (res == CMD_REJECT);
      case (state_q)
        IDLE: if (start) begin
          state_q     <= BOUNCE_DN;
          ready_q     <= 1'b0;
          scan_q      <= cmd_scan;
          sense_idx_q <= cmd_sense;
        end
        BOUNCE_DN: if (done) begin
          state_q    <= HELD;
          ready_q    <= 1'b1;
          key_down_q <= 1'b1;
        end
        HELD: if (start) begin
          state_q    <= BOUNCE_UP;
          ready_q    <= 1'b0;
          key_down_q <= 1'b0;
        end
        BOUNCE_UP: if (done) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sense_out = sense_q;
  assign cmd_ready = ready_q;
  assign key_down  = key_down_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed scenarios with a cycle-count reference model;
// expected sense_out values are queued when scan_in is driven and compared
// one clock later.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_press = 1'b0;
  logic [1:0] cmd_scan = '0;
  logic [2:0] cmd_sense = '0;
  logic [3:0] scan_in = 4'b1110;
  logic [5:0] sense_out;
  logic       key_down;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: 0 idle, 1 bounce down, 2 held, 3 bounce up
  int m_mode = 0;
  int m_k = 0;
  int m_scan = 0;
  int m_sense = 0;
  bit rot_on = 1'b1;
  logic [5:0] sb_q[$];

  keypad_emulator dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_press(cmd_press), .cmd_scan(cmd_scan), .cmd_sense(cmd_sense),
    .scan_in(scan_in), .sense_out(sense_out),
    .key_down(key_down), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the inputs of the current cycle, advance, compare.
  task automatic step();
    logic [5:0] exp_s;
    bit contact;
    bit exp_err;
    bit same;
    case (m_mode)
      0:       contact = 1'b0;
      1:       contact = (((m_k - 1) / 8) % 2) == 0;
      2:       contact = 1'b1;
      default: contact = (((m_k - 1) / 8) % 2) == 1;
    endcase
    exp_s = 6'h3f;
    if (!rst && contact && scan_in[m_scan] == 1'b0) exp_s[m_sense] = 1'b0;
    sb_q.push_back(exp_s);
    exp_err = 1'b0;
    if (rst) begin
      m_mode = 0;
    end else if (m_mode == 1 || m_mode == 3) begin
      if (m_k == 32) m_mode = (m_mode == 1) ? 2 : 0;
      else m_k++;
    end else if (cmd_valid) begin
      same = (int'(cmd_scan) == m_scan) && (int'(cmd_sense) == m_sense);
      if (cmd_scan >= 2'd3 + 2'd0 && cmd_scan > 2'd3) exp_err = 1'b1; // never: 2-bit scan fits N_SCAN
      if (int'(cmd_sense) >= 6) exp_err = 1'b1;
      else if (m_mode == 0) begin
        if (cmd_press) begin
          m_mode = 1; m_k = 1; m_scan = int'(cmd_scan); m_sense = int'(cmd_sense);
        end else exp_err = 1'b1;
      end else begin
        if (!same) exp_err = 1'b1;
        else if (!cmd_press) begin m_mode = 3; m_k = 1; end
      end
    end
    @(posedge clk); #1;
    chk("sense_out", 32'(sense_out), 32'(sb_q.pop_front()));
    chk("err", 32'(err), 32'(exp_err));
    chk("key_down", 32'(key_down), 32'(m_mode == 2));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0 || m_mode == 2));
    if (rot_on) scan_in = {scan_in[2:0], scan_in[3]};
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input bit p, input int sc, input int se);
    cmd_valid = 1'b1; cmd_press = p; cmd_scan = 2'(sc); cmd_sense = 3'(se);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // reset state
    steps(2);
    rst = 1'b0;
    steps(2);

    // rejects from IDLE
    send(1'b0, 2, 3);          // release in IDLE
    step();
    send(1'b1, 1, 6);          // sense out of range
    step();

    // press (2,3): bounce then HELD at cycle 33
    send(1'b1, 2, 3);
    steps(40);

    // HELD: foreign press rejected, same press ignored, foreign release rejected
    send(1'b1, 1, 1);
    step();
    send(1'b1, 2, 3);
    step();
    send(1'b0, 1, 1);
    step();
    chk("held_after_rejects", 32'(key_down), 32'd1);

    // release (2,3)
    send(1'b0, 2, 3);
    steps(40);

    // multi-low scan lines while HELD on (0,5)
    send(1'b1, 0, 5);
    steps(34);
    rot_on = 1'b0;
    scan_in = 4'b0000;
    steps(2);
    chk("all_scan_low", 32'(sense_out), 32'h1f);
    scan_in = 4'b1110;
    steps(2);
    chk("scan0_low", 32'(sense_out), 32'h1f);
    rot_on = 1'b1;
    send(1'b0, 0, 5);
    steps(40);

    // reset at cycle 12 of press bounce, then a clean press/release
    send(1'b1, 1, 4);
    steps(11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_sense", 32'(sense_out), 32'h3f);
    send(1'b1, 1, 4);
    steps(40);
    send(1'b0, 1, 4);
    steps(40);

    // commands during BOUNCE_DN are ignored
    send(1'b1, 3, 0);
    steps(4);
    cmd_valid = 1'b1; cmd_press = 1'b0; cmd_scan = 2'd1; cmd_sense = 3'd7;
    steps(6);
    cmd_valid = 1'b0;
    steps(30);
    chk("held_after_busy_cmds", 32'(key_down), 32'd1);
    send(1'b0, 3, 0);
    steps(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Synthesizable 4x6 matrix-keypad model. It is the responder side of the keypad scan interface.
- Watches the scanner's active-low scan lines (key_out).
- Drives the active-low sense lines (key_in) exactly as a physical contact would, including programmable contact bounce.
- Used for on-board self-test and as a bench model for the keyboard scanner and 7-segment display path.

Parameters:
- N_SCAN, 4: number of scan lines (scanner outputs).
- N_SENSE, 6: number of sense lines (scanner inputs).
- BOUNCE_CYCLES, 8: clk cycles per bounce period; must be at least 1.
- BOUNCE_PERIODS, 4: alternating contact periods before settling; must be even and at least 2.
- CNT_W, 16: width of the bounce period counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command can be accepted this cycle
- cmd_press  in  1  1 = press, 0 = release
- cmd_scan  in  2  scan index of the key (0..N_SCAN-1)
- cmd_sense  in  3  sense index of the key (0..N_SENSE-1)
- scan_in  in  N_SCAN  scanner scan lines, active-low
- sense_out  out  N_SENSE  sense lines to the scanner, active-low, idle all 1
- key_down  out  1  contact settled closed (HELD state)
- err  out  1  one-cycle pulse on a rejected command

Behaviour:
Reset values:
- sense_out = all 1s, cmd_ready = 1, key_down = 0, err = 0, state = IDLE, contact = open.
- Reset mid-bounce or while HELD: sense_out is all 1s on the cycle after rst is sampled high.

Handshake:
- A command is accepted when cmd_valid = 1, cmd_ready = 1 and the command is legal.
- cmd_ready = 1 in IDLE and HELD; cmd_ready = 0 in BOUNCE_DN and BOUNCE_UP.
- cmd_valid while cmd_ready = 0: ignored, no err.

Command legality (all rejected commands pulse err for 1 cycle and leave state unchanged):
- cmd_sense >= N_SENSE or cmd_scan >= N_SCAN: rejected.
- Release in IDLE: rejected.
- Press in HELD on a different key: rejected.
- Press in HELD on the same key: ignored, no err.
- Release in HELD on a key different from the latched one: rejected.

State machine:
- IDLE, press accepted: latch scan and sense indices, enter BOUNCE_DN, clear the period counter.
- BOUNCE_DN: contact closed in periods 0, 2, 4, ...; open in periods 1, 3, ...
  - Each period lasts BOUNCE_CYCLES cycles.
  - After BOUNCE_PERIODS periods, go to HELD.
- HELD: contact closed, key_down = 1. Release accepted: enter BOUNCE_UP.
- BOUNCE_UP: contact open in even periods, closed in odd periods. After BOUNCE_PERIODS periods, go to IDLE with contact open.
- Total bounce duration in each direction = BOUNCE_PERIODS * BOUNCE_CYCLES cycles after acceptance.

Sense output, registered with 1-cycle latency from scan_in:
- sense_out[s] = 0 iff contact closed, s == latched sense, and scan_in[latched scan] == 0.
- All other sense bits are 1.
- If several scan lines are low, only the latched scan line matters.
- Only a single key is modelled; there is no ghosting.

Decomposition:
- Package keypad_emu_pkg holds:
  - state enum {IDLE, BOUNCE_DN, HELD, BOUNCE_UP};
  - index width constants SCAN_IDX_W = 2 and SENSE_IDX_W = 3;
  - a legality check function.
- Sub-module bounce_timer: CNT_W cycle counter plus period counter.
  - Inputs: start, clk, rst.
  - Outputs: period parity and a done pulse after BOUNCE_PERIODS periods.
- The FSM and output register live in the top level.

Test Plan:
All scenarios use default parameters (bounce = 32 cycles). The bench scanner rotates scan_in through 1110, 1101, 1011, 0111, one step per cycle.
1. Press scan = 2, sense = 3 from IDLE.
   - During cycles 1-8 after acceptance, sense_out = 110111 one cycle after each cycle in which scan_in = 1011; otherwise 111111.
   - Cycles 9-16: sense_out stays 111111.
   - key_down = 1 at cycle 33.
2. Release the same key from HELD.
   - Bounce alternates open/closed over 32 cycles, then IDLE.
   - sense_out stays 111111 thereafter; cmd_ready = 1.
3. Reject cases, each with cmd_ready = 1:
   - release in IDLE → err = 1 for one cycle;
   - press with sense = 6 → err = 1 for one cycle;
   - press of a different key in HELD → err = 1 for one cycle, latched key unchanged.
4. Hold scan_in = 0000 while HELD on scan = 0, sense = 5 → sense_out = 011111. Then set scan_in = 1110 → sense_out remains 011111.
5. Assert rst at cycle 12 of BOUNCE_DN → next cycle: sense_out = 111111, cmd_ready = 1, key_down = 0. A following press completes normally.
6. Drive cmd_valid during BOUNCE_DN → no err, no state change; HELD is still reached at cycle 33.
